rom_browser: RTL and testbench
==============================

ROM_BROWSER -- requirements
Module: rom_browser

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-003 SHALL have parameter NDIG, default 4, number of BCD digits produced.
REQ-004 SHALL have parameter CNT_MAX, default 24'd9_999_999, auto-step period minus one, in clocks.
REQ-005 SHALL have parameter DEB_MAX, default 20'd999_999, debounce stable time minus one, in clocks.
REQ-006 SHALL have port sys_clk, input, 1, sole clock.
REQ-007 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports key_up, key_down and key_mode, input, 1 each, raw asynchronous active-low pushbuttons.
REQ-009 SHALL have port rom_addr, output, ADDR_W, registered ROM address.
REQ-010 SHALL have port rom_data, input, DATA_W, output of the synchronous ROM, one-cycle read latency.
REQ-011 SHALL have port bcd_out, output, 4*NDIG, packed BCD with the least significant digit in [3:0].
REQ-012 SHALL have port bcd_valid, output, 1, one-cycle pulse when bcd_out updates.
REQ-013 SHALL have port bcd_ovf, output, 1, high when the value shown needs more than NDIG digits.
REQ-014 SHALL have port mode_auto, output, 1, high in AUTO mode.

Function
REQ-015 Each key SHALL pass through a 2-FF synchroniser, then a debouncer that accepts a new level only after DEB_MAX+1 consecutive stable cycles; a press SHALL be a one-cycle pulse on the debounced high-to-low transition.
REQ-016 In MANUAL mode, an up press SHALL increment rom_addr, wrapping from 2^ADDR_W-1 to 0; a down press SHALL decrement it, wrapping from 0 to 2^ADDR_W-1.
REQ-017 Up and down presses in the same cycle SHALL leave rom_addr unchanged.
REQ-018 A mode press SHALL toggle between MANUAL and AUTO and SHALL clear the step counter.
REQ-019 In AUTO mode, the step counter SHALL count 0..CNT_MAX, then wrap; rom_addr SHALL increment with wrap on the cycle the counter wraps; up and down presses SHALL be ignored.
REQ-020 Conversion FSM states SHALL be IDLE, WAIT, SHIFT and DONE; every rom_addr change, and the first cycle after reset, SHALL move the FSM to WAIT.
REQ-021 WAIT SHALL last 2 cycles; rom_data SHALL then be sampled into a shift register.
REQ-022 SHIFT SHALL run DATA_W double-dabble iterations, one per cycle: first add 3 to each digit >= 5, then shift left one bit.
REQ-023 Any 1 shifted out of the top BCD digit SHALL set an internal overflow flag.
REQ-024 DONE SHALL last one cycle: load bcd_out, load bcd_ovf, pulse bcd_valid, then return to IDLE.
REQ-025 Latency SHALL be exactly DATA_W+4 cycles from a rom_addr change to bcd_valid.
REQ-026 A rom_addr change during WAIT or SHIFT SHALL abort the conversion in progress and restart at WAIT; bcd_out SHALL hold its previous value until DONE.

Reset
REQ-027 Reset SHALL set rom_addr=0, bcd_out=0, bcd_valid=0, bcd_ovf=0, mode_auto=0, all counters to 0, and the FSM to WAIT.
REQ-028 Reset SHALL set the debounced key state to released (1).
REQ-029 Reset assertion mid-conversion SHALL discard the partial result.

Configuration
REQ-030 With macro ROM_BROWSER_AUTO_EN defined, the AUTO mode, the step counter and key_mode handling SHALL be present.
REQ-031 Without ROM_BROWSER_AUTO_EN, key_mode SHALL be ignored, mode_auto SHALL be tied to 0 and no step counter SHALL be synthesised.

Structure
REQ-032 Package rom_browser_pkg SHALL hold the mode enum (MANUAL, AUTO), the conversion-state typedef and the default CNT_MAX and DEB_MAX constants.
REQ-033 Sub-module key_debounce (synchroniser, debouncer, press pulse) SHALL be instantiated once per key.

Verification (DEB_MAX=3, CNT_MAX=9, ROM holds data=address)
REQ-034 Release reset -> bcd_valid pulses 12 cycles later with bcd_out=16'h0000 and bcd_ovf=0.
REQ-035 In MANUAL mode: press down at addr 0 -> rom_addr=255, bcd_out=16'h0255; then press up -> rom_addr=0.
REQ-036 Assert up and down in the same cycle at addr 7 -> rom_addr stays 7 and no bcd_valid pulse occurs.
REQ-037 Mode press -> mode_auto=1; rom_addr advances every 10 cycles; up presses are ignored; at addr 255 the next step goes to 0.
REQ-038 Change address again 5 cycles into a conversion -> exactly one bcd_valid, carrying the new value, 12 cycles after the last change.
REQ-039 With NDIG=2, address 200 -> bcd_out=8'h00 and bcd_ovf=1; a key bounce shorter than 4 cycles -> no press event.

Source files
------------

// File: rtl/rom_browser_pkg.sv
// Shared types and default timing constants for rom_browser.
package rom_browser_pkg;

   typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } conv_state_e;

   localparam logic [23:0] CNT_MAX_DEF = 24'd9_999_999;
   localparam logic [19:0] DEB_MAX_DEF = 20'd999_999;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchroniser, stable-time debouncer and a one-cycle
// pulse on the debounced press (high-to-low) transition.
module key_debounce
   import rom_browser_pkg::*;
#(
   parameter logic [19:0] DEB_MAX = DEB_MAX_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   logic [1:0]  r_sync;
   logic        r_state;
   logic [19:0] r_cnt;

   // A new level is taken only after DEB_MAX+1 consecutive differing samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync  <= 2'b11;
         r_state <= 1'b1;
         r_cnt   <= '0;
         o_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         o_press <= 1'b0;
         if (r_sync[1] == r_state) begin
            r_cnt <= '0;
         end else if (r_cnt == DEB_MAX) begin
            r_state <= r_sync[1];
            r_cnt   <= '0;
            o_press <= r_state;
         end else begin
            r_cnt <= r_cnt + 20'd1;
         end
      end
   end

endmodule

// File: rtl/rom_browser.sv
// Steps a ROM address with debounced keys and converts each ROM word to BCD.
// Define ROM_BROWSER_AUTO_EN to add the AUTO stepping mode driven by key_mode.
module rom_browser
   import rom_browser_pkg::*;
#(
   parameter int          ADDR_W  = 8,
   parameter int          DATA_W  = 8,
   parameter int          NDIG    = 4,
   parameter logic [23:0] CNT_MAX = CNT_MAX_DEF,
   parameter logic [19:0] DEB_MAX = DEB_MAX_DEF
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                key_up,
   input  logic                key_down,
   input  logic                key_mode,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [DATA_W-1:0]   rom_data,
   output logic [4*NDIG-1:0]   bcd_out,
   output logic                bcd_valid,
   output logic                bcd_ovf,
   output logic                mode_auto
);

   localparam int BW = 4*NDIG;
   localparam int CW = $clog2(DATA_W+1);

   logic w_up, w_down, w_auto, w_auto_step, w_inc, w_dec;

   key_debounce #(.DEB_MAX(DEB_MAX)) u_key_up (
      .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_key_n(key_up), .o_press(w_up));
   key_debounce #(.DEB_MAX(DEB_MAX)) u_key_down (
      .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_key_n(key_down), .o_press(w_down));

`ifdef ROM_BROWSER_AUTO_EN
   logic        w_mode;
   mode_e       r_mode;
   logic [23:0] r_step;

   key_debounce #(.DEB_MAX(DEB_MAX)) u_key_mode (
      .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_key_n(key_mode), .o_press(w_mode));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_mode <= MANUAL;
         r_step <= '0;
      end else if (w_mode) begin
         r_mode <= (r_mode == AUTO) ? MANUAL : AUTO;
         r_step <= '0;
      end else if (r_mode == AUTO) begin
         r_step <= (r_step == CNT_MAX) ? '0 : r_step + 24'd1;
      end
   end

   assign w_auto      = (r_mode == AUTO);
   // A mode press restarts the period, so it also suppresses a coincident step.
   assign w_auto_step = w_auto & ~w_mode & (r_step == CNT_MAX);
`else
   logic        w_unused_mode;
   logic [23:0] w_unused_cnt;
   assign w_unused_mode = key_mode;
   assign w_unused_cnt  = CNT_MAX;
   assign w_auto        = 1'b0;
   assign w_auto_step   = 1'b0;
`endif

   assign mode_auto = w_auto;
   assign w_inc     = w_auto ? w_auto_step : (w_up & ~w_down);
   assign w_dec     = ~w_auto & w_down & ~w_up;

   logic [ADDR_W-1:0] r_addr;
   logic              r_chg;

   // r_chg comes out of reset set so the first cycle starts a conversion.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_addr <= '0;
         r_chg  <= 1'b1;
      end else begin
         r_chg <= w_inc | w_dec;
         if (w_inc)      r_addr <= r_addr + ADDR_W'(1);
         else if (w_dec) r_addr <= r_addr - ADDR_W'(1);
      end
   end

   assign rom_addr = r_addr;

   conv_state_e       r_state;
   logic              r_wcnt;
   logic [CW-1:0]     r_icnt;
   logic [BW-1:0]     r_bcd;
   logic [DATA_W-1:0] r_bin;
   logic              r_ovf;
   logic [BW-1:0]     r_bcd_out;
   logic              r_bcd_valid;
   logic              r_bcd_ovf;
   logic [BW-1:0]     w_adj;

   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < NDIG; d++)
         if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= WAIT;
         r_wcnt      <= 1'b0;
         r_icnt      <= '0;
         r_bcd       <= '0;
         r_bin       <= '0;
         r_ovf       <= 1'b0;
         r_bcd_out   <= '0;
         r_bcd_valid <= 1'b0;
         r_bcd_ovf   <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         if (r_chg) begin
            r_state <= WAIT;
            r_wcnt  <= 1'b0;
         end else begin
            case (r_state)
               IDLE: ;
               WAIT: begin
                  if (r_wcnt) begin
                     r_state <= SHIFT;
                     r_bin   <= rom_data;
                     r_bcd   <= '0;
                     r_ovf   <= 1'b0;
                     r_icnt  <= '0;
                  end else begin
                     r_wcnt <= 1'b1;
                  end
               end
               SHIFT: begin
                  {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                  r_ovf  <= r_ovf | w_adj[BW-1];
                  r_icnt <= r_icnt + CW'(1);
                  if (r_icnt == CW'(DATA_W-1)) r_state <= DONE;
               end
               DONE: begin
                  r_bcd_out   <= r_bcd;
                  r_bcd_ovf   <= r_ovf;
                  r_bcd_valid <= 1'b1;
                  r_state     <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bcd_out   = r_bcd_out;
   assign bcd_valid = r_bcd_valid;
   assign bcd_ovf   = r_bcd_ovf;

endmodule

// File: tb/tb_rom_browser.sv
// Scoreboard bench for rom_browser: a 4-digit and a 2-digit instance share keys
// and a data=address ROM; a negedge monitor checks address steps and results.
module tb_rom_browser;

   logic        clk = 1'b0, rst_n = 1'b1, k_up = 1'b1, k_dn = 1'b1, k_md = 1'b1;
   logic [7:0]  addr1, addr2, rom1 = '0, rom2 = '0;
   logic [15:0] bcd1;
   logic [7:0]  bcd2;
   logic        v1, v2, o1, o2, m1, m2;

   int   n_tests = 0, n_fail = 0, cyc = 0, n_valid = 0;
   logic [7:0] model_addr = '0, mon_prev = '0;
   int   q_addr[$];
   bit   tb_auto = 1'b0, pend = 1'b0, rst_q = 1'b0, saw_wrap = 1'b0;
   int   pend_due = 0, pend_val = 0, last_step = -1, mon_exp = 0;

   rom_browser #(.ADDR_W(8), .DATA_W(8), .NDIG(4), .CNT_MAX(24'd9), .DEB_MAX(20'd3)) u_dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .key_up(k_up), .key_down(k_dn), .key_mode(k_md),
      .rom_addr(addr1), .rom_data(rom1), .bcd_out(bcd1), .bcd_valid(v1), .bcd_ovf(o1),
      .mode_auto(m1));

   rom_browser #(.ADDR_W(8), .DATA_W(8), .NDIG(2), .CNT_MAX(24'd9), .DEB_MAX(20'd3)) u_dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n), .key_up(k_up), .key_down(k_dn), .key_mode(k_md),
      .rom_addr(addr2), .rom_data(rom2), .bcd_out(bcd2), .bcd_valid(v2), .bcd_ovf(o2),
      .mode_auto(m2));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rom1 <= addr1;
      rom2 <= addr2;
   end

   function automatic logic [15:0] to_bcd(input int v, input int nd);
      logic [15:0] r;
      int t;
      r = '0;
      t = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_prev  = '0;
         pend      = 1'b0;
         last_step = -1;
      end else begin
         if (!rst_q) begin
            pend     = 1'b1;
            pend_due = cyc + 12;
            pend_val = 0;
         end
         if (addr1 != mon_prev) begin
            if (tb_auto) begin
               mon_exp = (int'(mon_prev) + 1) % 256;
               check("auto_step", 32'(addr1), 32'(mon_exp));
               if (last_step >= 0) check("auto_period", 32'(cyc - last_step), 32'd10);
               if (mon_prev == 8'd255 && addr1 == 8'd0) saw_wrap = 1'b1;
               last_step = cyc;
            end else begin
               last_step = -1;
               if (q_addr.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  mon_exp = int'(addr1);
                  $display("FAIL unexpected_change: rom_addr %0d, expected it to stay %0d", addr1, mon_prev);
               end else begin
                  mon_exp = q_addr.pop_front();
                  check("addr", 32'(addr1), 32'(mon_exp));
               end
            end
            mon_prev = addr1;
            pend     = 1'b1;
            pend_due = cyc + 12;
            pend_val = mon_exp;
         end
         if (v1) begin
            n_valid++;
            if (!pend) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_valid: bcd_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
               check("latency", 32'(cyc), 32'(pend_due));
               check("bcd4", 32'(bcd1), 32'(to_bcd(pend_val, 4)));
               check("ovf4", 32'(o1), 32'(pend_val >= 10000));
               check("valid2", 32'(v2), 32'd1);
               check("bcd2", 32'(bcd2), 32'(to_bcd(pend_val, 2)));
               check("ovf2", 32'(o2), 32'(pend_val >= 100));
               pend = 1'b0;
            end
         end else begin
            if (v2) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_valid2: bcd_valid=1 at cycle %0d, expected 0", cyc);
            end
            if (pend && cyc > pend_due) begin
               n_tests++;
               n_fail++;
               $display("FAIL missing_valid: none by cycle %0d, expected at %0d", cyc, pend_due);
               pend = 1'b0;
            end
         end
      end
      rst_q = rst_n;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit up, input bit dn, input int hold);
      if (!tb_auto && (up != dn)) begin
         model_addr = up ? model_addr + 8'd1 : model_addr - 8'd1;
         q_addr.push_back(int'(model_addr));
      end
      @(negedge clk);
      k_up = ~up;
      k_dn = ~dn;
      tick(hold);
      k_up = 1'b1;
      k_dn = 1'b1;
      tick(12);
   endtask

   task automatic press_mode();
      @(negedge clk);
      k_md = 1'b0;
      tick(10);
      k_md = 1'b1;
      tick(12);
   endtask

   task automatic goto_addr(input logic [7:0] a);
      logic [7:0] d;
      for (int i = 0; i < 256 && model_addr != a; i++) begin
         d = a - model_addr;
         press(d < 8'd128, d >= 8'd128, 8);
      end
   endtask

   initial begin
      int nv;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr", 32'(addr1), 32'd0);
      check("rst_bcd", 32'(bcd1), 32'd0);
      check("rst_valid", 32'(v1), 32'd0);
      check("rst_ovf", 32'(o1), 32'd0);
      check("rst_mode", 32'(m1), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick(30);

      press(1'b0, 1'b1, 10);            // 0 -> 255
      press(1'b1, 1'b0, 10);            // 255 -> 0
      goto_addr(8'd7);
      nv = n_valid;
      press(1'b1, 1'b1, 10);
      tick(10);
      check("both_addr", 32'(addr1), 32'd7);
      check("both_no_valid", 32'(n_valid - nv), 32'd0);

      // second change lands 5 cycles into the first conversion
      nv = n_valid;
      model_addr = model_addr + 8'd1;
      q_addr.push_back(int'(model_addr));
      model_addr = model_addr - 8'd1;
      q_addr.push_back(int'(model_addr));
      @(negedge clk);
      k_up = 1'b0;
      tick(5);
      k_dn = 1'b0;
      tick(7);
      k_up = 1'b1;
      tick(5);
      k_dn = 1'b1;
      tick(30);
      check("abort_one_valid", 32'(n_valid - nv), 32'd1);

      @(negedge clk);
      k_up = 1'b0; tick(2);
      k_up = 1'b1; tick(2);
      k_up = 1'b0; tick(3);
      k_up = 1'b1; tick(20);
      check("bounce_addr", 32'(addr1), 32'(model_addr));

      repeat (30) begin
         case ($urandom_range(0, 2))
            0:       press(1'b1, 1'b0, int'($urandom_range(8, 14)));
            1:       press(1'b0, 1'b1, int'($urandom_range(8, 14)));
            default: press(1'b1, 1'b1, int'($urandom_range(8, 14)));
         endcase
         tick(int'($urandom_range(0, 8)));
      end

      goto_addr(8'd200);
      tick(5);
      check("ndig2_bcd", 32'(bcd2), 32'h00);
      check("ndig2_ovf", 32'(o2), 32'd1);
      check("ndig4_bcd", 32'(bcd1), 32'h0200);

`ifdef ROM_BROWSER_AUTO_EN
      goto_addr(8'd250);
      tick(5);
      tb_auto = 1'b1;
      press_mode();
      check("mode_on", 32'(m1), 32'd1);
      press(1'b1, 1'b0, 10);
      tick(80);
      check("auto_wrap", 32'(saw_wrap), 32'd1);
      press_mode();
      check("mode_off", 32'(m1), 32'd0);
      tick(5);
      tb_auto = 1'b0;
      model_addr = mon_prev;
      tick(20);
      press(1'b1, 1'b0, 10);
`else
      press_mode();
      check("mode_ignored", 32'(m1), 32'd0);
      tick(20);
      check("mode_no_step", 32'(addr1), 32'(model_addr));
`endif

      tick(40);
      check("queue_empty", 32'(q_addr.size()), 32'd0);
      check("no_pending", 32'(pend), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
